// File: rtl/chan_sel_sequencer.sv
// One-hot electrode channel selector with direct-load and masked auto-scan modes.
// Every channel change passes through DEAD_CYC all-off cycles (break-before-make).
module chan_sel_sequencer #(
  parameter int SEL_W    = 3,
  parameter int DEAD_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    load,
  input  logic                    step,
  input  logic [(1<<SEL_W)-1:0]   scan_mask,
  output logic [(1<<SEL_W)-1:0]   dout,
  output logic [SEL_W-1:0]        cur_idx,
  output logic                    active,
  output logic                    busy,
  output logic                    wrap,
  output logic [1:0]              o_dbg_state
);

  localparam int N_CH = 1 << SEL_W;
  localparam logic [7:0] GAP_LAST = (DEAD_CYC > 0) ? 8'(DEAD_CYC - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_cur_idx, w_cur_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [N_CH-1:0]   r_dout, w_dout_nxt;
  logic              r_active, r_busy, r_wrap, w_wrap_nxt;

  logic [SEL_W:0]    w_scan_base, w_pos;
  logic              w_scan_hit, w_scan_wrap;
  logic [SEL_W-1:0]  w_scan_idx;
  logic              w_req, w_tgt_ok, w_tgt_wrap;
  logic [SEL_W-1:0]  w_target;

  // Circular search for the lowest eligible channel after the current one; the
  // extra top bit of the unwrapped position tells whether the search passed N_CH-1.
  always_comb begin
    w_scan_base = (r_state == S_ACTIVE) ? ({1'b0, r_cur_idx} + (SEL_W+1)'(1)) : '0;
    w_pos       = '0;
    w_scan_hit  = 1'b0;
    w_scan_idx  = '0;
    w_scan_wrap = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_pos = w_scan_base + (SEL_W+1)'(i);
      if (scan_mask[w_pos[SEL_W-1:0]]) begin
        w_scan_hit  = 1'b1;
        w_scan_idx  = w_pos[SEL_W-1:0];
        w_scan_wrap = w_pos[SEL_W];
      end
    end
  end

  // Request handshake: load (mode=0) or step (mode=1) is a single-cycle strobe,
  // taken only when enable=1 and no gap is running (busy=0); otherwise it is dropped.
  always_comb begin
    w_req      = enable && (r_state != S_GAP) && (mode ? step : load);
    w_target   = mode ? w_scan_idx : sel_in;
    w_tgt_ok   = mode ? w_scan_hit : 1'b1;
    w_tgt_wrap = mode && w_scan_wrap;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_idx;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_tgt_ok) begin
            w_state_nxt = S_ACTIVE;
            w_cur_nxt   = w_target;
          end
        end
        S_ACTIVE: begin
          if (w_req && w_tgt_ok) begin
            w_wrap_nxt = w_tgt_wrap;
            if (w_target != r_cur_idx) begin
              w_cur_nxt = w_target;
              if (DEAD_CYC != 0) begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = GAP_LAST;
              end
            end
          end
        end
        S_GAP: begin
          if (r_cnt == 8'd0) begin
            w_state_nxt = S_ACTIVE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_dout_nxt = '0;
    if (w_state_nxt == S_ACTIVE) begin
      w_dout_nxt[w_cur_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cur_idx <= '0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_active  <= 1'b0;
      r_busy    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_idx <= w_cur_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_active  <= (w_state_nxt == S_ACTIVE);
      r_busy    <= (w_state_nxt == S_GAP);
      r_wrap    <= w_wrap_nxt;
    end
  end

  assign dout        = r_dout;
  assign cur_idx     = r_cur_idx;
  assign active      = r_active;
  assign busy        = r_busy;
  assign wrap        = r_wrap;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chan_sel_sequencer.sv
// Bench for chan_sel_sequencer: directed vector table, a DEAD_CYC=0 check, and
// randomized traffic scored against a behavioural model.
module tb_chan_sel_sequencer;

  localparam int SEL_W = 3;
  localparam int N_CH  = 8;
  localparam int DEAD  = 2;

  logic             clk = 1'b0;
  logic             rst_n, enable, mode, load, step;
  logic [SEL_W-1:0] sel_in;
  logic [N_CH-1:0]  scan_mask;

  logic [N_CH-1:0]  dout, dout0;
  logic [SEL_W-1:0] cur_idx, cur_idx0;
  logic             active, busy, wrap, active0, busy0, wrap0;
  logic [1:0]       dbg_state, dbg_state0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chan_sel_sequencer #(.SEL_W(SEL_W), .DEAD_CYC(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_in(sel_in),
    .load(load), .step(step), .scan_mask(scan_mask), .dout(dout),
    .cur_idx(cur_idx), .active(active), .busy(busy), .wrap(wrap),
    .o_dbg_state(dbg_state)
  );

  chan_sel_sequencer #(.SEL_W(SEL_W), .DEAD_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel_in(sel_in),
    .load(load), .step(step), .scan_mask(scan_mask), .dout(dout0),
    .cur_idx(cur_idx0), .active(active0), .busy(busy0), .wrap(wrap0),
    .o_dbg_state(dbg_state0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_onehot(input string name);
    check({name, "_pop"},  32'($countones(dout)  <= 1), 32'd1);
    check({name, "_pop0"}, 32'($countones(dout0) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             rst_n, en, mode;
    logic [SEL_W-1:0] sel;
    logic             ld, st;
    logic [N_CH-1:0]  mask;
    logic [N_CH-1:0]  e_dout;
    logic [SEL_W-1:0] e_idx;
    logic             e_act, e_busy, e_wrap;
  } vec_t;

  vec_t vec [28];

  // ---------------- behavioural model ----------------
  bit               m_lit;
  int               m_dark;
  int               m_idx;
  bit               m_wrap;
  logic [N_CH-1:0]  exp_q[$];

  task automatic model_edge();
    int tgt;
    int base;
    bit wrapped;
    bit found;
    m_wrap = 1'b0;
    if (!rst_n) begin
      m_lit = 1'b0; m_dark = 0; m_idx = 0;
      return;
    end
    if (!enable) begin
      m_lit = 1'b0; m_dark = 0;
      return;
    end
    if (m_dark > 0) begin
      m_dark--;
      if (m_dark == 0) m_lit = 1'b1;
      return;
    end
    if (!(mode ? step : load)) return;
    wrapped = 1'b0;
    tgt = 0;
    if (!mode) begin
      tgt = int'(sel_in);
    end else begin
      if (scan_mask == '0) return;
      base  = m_lit ? m_idx : N_CH - 1;
      found = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
        if (!found && scan_mask[(base + k) % N_CH]) begin
          found   = 1'b1;
          tgt     = (base + k) % N_CH;
          wrapped = m_lit && (base + k >= N_CH);
        end
      end
    end
    if (!m_lit) begin
      m_idx = tgt;
      m_lit = 1'b1;
    end else begin
      m_wrap = wrapped;
      if (tgt != m_idx) begin
        m_idx = tgt;
        m_lit = 1'b0;
        m_dark = DEAD;
      end
    end
  endtask

  initial begin
    logic [N_CH-1:0] exp_dout;
    int r;

    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; load = 1'b0; step = 1'b0;
    sel_in = '0; scan_mask = '0;

    //               rst en md sel   ld st mask    | dout   idx  act busy wrap
    vec[0]  = '{1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,8'h00, 8'h00,3'd0,1'b0,1'b0,1'b0};
    vec[1]  = '{1'b1,1'b1,1'b0,3'd5,1'b1,1'b0,8'h00, 8'h20,3'd5,1'b1,1'b0,1'b0};
    vec[2]  = '{1'b1,1'b1,1'b0,3'd5,1'b0,1'b0,8'h00, 8'h20,3'd5,1'b1,1'b0,1'b0};
    vec[3]  = '{1'b1,1'b1,1'b0,3'd2,1'b1,1'b0,8'h00, 8'h00,3'd2,1'b0,1'b1,1'b0};
    vec[4]  = '{1'b1,1'b1,1'b0,3'd7,1'b1,1'b0,8'h00, 8'h00,3'd2,1'b0,1'b1,1'b0};
    vec[5]  = '{1'b1,1'b1,1'b0,3'd7,1'b0,1'b0,8'h00, 8'h04,3'd2,1'b1,1'b0,1'b0};
    vec[6]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,1'b0,8'h00, 8'h04,3'd2,1'b1,1'b0,1'b0};
    vec[7]  = '{1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,8'h00, 8'h00,3'd2,1'b0,1'b0,1'b0};
    vec[8]  = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h92, 8'h02,3'd1,1'b1,1'b0,1'b0};
    vec[9]  = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h92, 8'h00,3'd4,1'b0,1'b1,1'b0};
    vec[10] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h92, 8'h00,3'd4,1'b0,1'b1,1'b0};
    vec[11] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b0,8'h92, 8'h10,3'd4,1'b1,1'b0,1'b0};
    vec[12] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h92, 8'h00,3'd7,1'b0,1'b1,1'b0};
    vec[13] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b0,8'h92, 8'h00,3'd7,1'b0,1'b1,1'b0};
    vec[14] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b0,8'h92, 8'h80,3'd7,1'b1,1'b0,1'b0};
    vec[15] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h92, 8'h00,3'd1,1'b0,1'b1,1'b1};
    vec[16] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b0,8'h92, 8'h00,3'd1,1'b0,1'b1,1'b0};
    vec[17] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b0,8'h92, 8'h02,3'd1,1'b1,1'b0,1'b0};
    vec[18] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h00, 8'h02,3'd1,1'b1,1'b0,1'b0};
    vec[19] = '{1'b1,1'b1,1'b1,3'd0,1'b0,1'b1,8'h02, 8'h02,3'd1,1'b1,1'b0,1'b1};
    vec[20] = '{1'b1,1'b1,1'b1,3'd6,1'b1,1'b0,8'h02, 8'h02,3'd1,1'b1,1'b0,1'b0};
    vec[21] = '{1'b1,1'b1,1'b0,3'd1,1'b1,1'b0,8'h00, 8'h02,3'd1,1'b1,1'b0,1'b0};
    vec[22] = '{1'b1,1'b1,1'b0,3'd3,1'b1,1'b0,8'h00, 8'h00,3'd3,1'b0,1'b1,1'b0};
    vec[23] = '{1'b0,1'b1,1'b0,3'd3,1'b1,1'b0,8'h00, 8'h00,3'd0,1'b0,1'b0,1'b0};
    vec[24] = '{1'b1,1'b1,1'b0,3'd6,1'b1,1'b0,8'h00, 8'h40,3'd6,1'b1,1'b0,1'b0};
    vec[25] = '{1'b1,1'b1,1'b0,3'd0,1'b1,1'b0,8'h00, 8'h00,3'd0,1'b0,1'b1,1'b0};
    vec[26] = '{1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,8'h00, 8'h00,3'd0,1'b0,1'b0,1'b0};
    vec[27] = '{1'b1,1'b1,1'b0,3'd3,1'b1,1'b0,8'h00, 8'h08,3'd3,1'b1,1'b0,1'b0};

    for (int i = 0; i < 28; i++) begin
      rst_n = vec[i].rst_n; enable = vec[i].en; mode = vec[i].mode;
      sel_in = vec[i].sel; load = vec[i].ld; step = vec[i].st; scan_mask = vec[i].mask;
      tick();
      check($sformatf("vec%0d_dout", i),   32'(dout),    32'(vec[i].e_dout));
      check($sformatf("vec%0d_idx", i),    32'(cur_idx), 32'(vec[i].e_idx));
      check($sformatf("vec%0d_active", i), 32'(active),  32'(vec[i].e_act));
      check($sformatf("vec%0d_busy", i),   32'(busy),    32'(vec[i].e_busy));
      check($sformatf("vec%0d_wrap", i),   32'(wrap),    32'(vec[i].e_wrap));
      check_onehot($sformatf("vec%0d", i));
    end

    // Zero-gap build: ACTIVE on 3, load 6 switches 8'h08 -> 8'h40 on one edge.
    check("dc0_pre_dout", 32'(dout0), 32'h08);
    sel_in = 3'd6; load = 1'b1;
    tick();
    load = 1'b0;
    check("dc0_dout",   32'(dout0),    32'h40);
    check("dc0_idx",    32'(cur_idx0), 32'd6);
    check("dc0_busy",   32'(busy0),    32'd0);
    check("dc0_active", 32'(active0),  32'd1);
    check("dc2_gap_dout", 32'(dout), 32'h00);
    check("dc2_gap_busy", 32'(busy), 32'd1);

    // Randomized traffic against the model.
    m_lit = 1'b0; m_dark = 0; m_idx = 0; m_wrap = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_n  = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 9) != 0);
      mode   = 1'($urandom_range(0, 1));
      sel_in = 3'($urandom_range(0, N_CH - 1));
      load   = ($urandom_range(0, 9) < 3);
      step   = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 9);
      if (r == 0)      scan_mask = '0;
      else if (r == 1) scan_mask = 8'(1) << $urandom_range(0, N_CH - 1);
      else             scan_mask = 8'($urandom_range(0, 255));
      @(posedge clk);
      model_edge();
      exp_q.push_back(m_lit ? (8'(1) << m_idx) : 8'h00);
      #1;
      exp_dout = exp_q.pop_front();
      check($sformatf("rnd%0d_dout", c),   32'(dout),    32'(exp_dout));
      check($sformatf("rnd%0d_idx", c),    32'(cur_idx), 32'(m_idx));
      check($sformatf("rnd%0d_active", c), 32'(active),  32'(m_lit));
      check($sformatf("rnd%0d_busy", c),   32'(busy),    32'(m_dark > 0));
      check($sformatf("rnd%0d_wrap", c),   32'(wrap),    32'(m_wrap));
      check_onehot($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
